// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   // Fetch controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4,
      FAULT = 3'd5
   } fetch_state_e;

   // Decoder word with every enable/write output deasserted
   localparam logic [15:0] INST_NOP = 16'h0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response channel between fetch (master) and imem (slave).
interface instruction_fetch_if #(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12
);
   logic                imem_req_valid;
   logic                imem_req_ready;
   logic [I_ADDR_W-1:0] imem_req_addr;
   logic                imem_rsp_valid;
   logic [INST_W-1:0]   imem_rsp_data;
   logic                imem_rsp_error;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues pc to imem, holds one returned word for the decoder,
// discards stale responses after a flush and latches a sticky bus-error fault.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [I_ADDR_W-1:0] pc,
   input  logic                advance,
   input  logic                flush,
   instruction_fetch_if.master imem,
   output logic [INST_W-1:0]   instruction,
   output logic                instruction_valid,
   output logic [I_ADDR_W-1:0] fetch_addr,
   output logic                fetch_fault
);

   localparam logic [2:0] S_IDLE  = 3'(IDLE);
   localparam logic [2:0] S_REQ   = 3'(REQ);
   localparam logic [2:0] S_WAIT  = 3'(WAIT);
   localparam logic [2:0] S_HOLD  = 3'(HOLD);
   localparam logic [2:0] S_DRAIN = 3'(DRAIN);
   localparam logic [2:0] S_FAULT = 3'(FAULT);

   localparam logic [INST_W-1:0] NOP_W = INST_W'(INST_NOP);

   logic [2:0]          state_q, state_d;
   logic [INST_W-1:0]   instr_q, instr_d;
   logic                valid_q, valid_d;
   logic [I_ADDR_W-1:0] addr_q,  addr_d;
   logic                fault_q, fault_d;
   logic                req_valid;

   // Next-state and register updates; instr_q is kept at NOP whenever no word is held
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      addr_d    = addr_q;
      fault_d   = fault_q;
      req_valid = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            req_valid = 1'b1;
            if (imem.imem_req_ready) begin
               addr_d  = pc;
               // a flush on the accept cycle makes this request stale
               state_d = flush ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               if (imem.imem_rsp_error) begin
                  // error outranks a coincident flush
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end else if (flush) begin
                  state_d = S_REQ;
               end else begin
                  instr_d = imem.imem_rsp_data;
                  valid_d = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (advance || flush) begin
               valid_d = 1'b0;
               instr_d = NOP_W;
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            // the stale response is dropped, data and error alike
            if (imem.imem_rsp_valid) state_d = S_REQ;
         end
         S_FAULT: ;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         instr_q <= NOP_W;
         valid_q <= 1'b0;
         addr_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         fault_q <= fault_d;
      end
   end

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc;
   assign instruction         = instr_q;
   assign instruction_valid   = valid_q;
   assign fetch_addr          = addr_q;
   assign fetch_fault         = fault_q;

endmodule
